// File: rtl/i2c_controller.sv
// rtl/i2c_controller.sv - I2C register write/read master; optional target clock stretching under I2C_CLOCK_STRETCH_EN
`timescale 1ns/1ps
module i2c_controller #(
    parameter int CLKS_PER_QUARTER = 62
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    inout  wire        io_scl,
    inout  wire        io_sda,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_dev_address,
    input  logic [7:0] i_register_address,
    input  logic [7:0] i_write_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic [7:0] o_read_data
);
    localparam int CW = (CLKS_PER_QUARTER > 1) ? $clog2(CLKS_PER_QUARTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_QUARTER - 1);

    typedef enum logic [2:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    regaddr_q, regaddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          samp_q, samp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          scl_low_q, scl_low_d;
    logic          sda_low_q, sda_low_d;
    logic [1:0]    scl_sync_q, scl_sync_d;
    logic [1:0]    sda_sync_q, sda_sync_d;

    logic          stall;
    logic          qend;
    logic          bit_scl_low;
    logic [2:0]    qtr_last;

    // Line drivers come straight from flops so the async reset releases the bus at once.
    assign io_scl      = scl_low_q ? 1'b0 : 1'bz;
    assign io_sda      = sda_low_q ? 1'b0 : 1'bz;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_nack      = nack_q;
    assign o_read_data = rdata_q;

`ifdef I2C_CLOCK_STRETCH_EN
    assign stall = (state_q != IDLE) && !scl_low_q && !scl_sync_q[1];
`else
    logic unused_scl;
    assign unused_scl = scl_sync_q[1];
    assign stall      = 1'b0;
`endif

    assign qend        = (cnt_q == CNT_LAST) && !stall;
    assign qtr_last    = (state_q == RSTART) ? 3'd4 : 3'd3;
    assign bit_scl_low = (qtr_q == 3'd0) || (qtr_q == 3'd3);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        regaddr_d  = regaddr_q;
        wdata_d    = wdata_q;
        samp_d     = samp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        rdata_d    = rdata_q;
        scl_sync_d = {scl_sync_q[0], io_scl};
        sda_sync_d = {sda_sync_q[0], io_sda};
        scl_low_d  = 1'b0;
        sda_low_d  = 1'b0;

        case (state_q)
            START: begin
                scl_low_d = (qtr_q == 3'd3);
                sda_low_d = (qtr_q != 3'd0);
            end
            TX_BYTE: begin
                scl_low_d = bit_scl_low;
                sda_low_d = !shift_q[7];
            end
            RX_ACK, RX_BYTE, TX_NACK: scl_low_d = bit_scl_low;
            RSTART: begin
                scl_low_d = (qtr_q == 3'd0) || (qtr_q == 3'd4);
                sda_low_d = (qtr_q >= 3'd2);
            end
            STOP: begin
                scl_low_d = (qtr_q == 3'd0);
                sda_low_d = (qtr_q <= 3'd1);
            end
            default: ;
        endcase

        if (state_q != IDLE && !stall) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end

        if (state_q == IDLE) begin
            if (i_start && !busy_q) begin
                rw_d      = i_rw;
                dev_d     = i_dev_address;
                regaddr_d = i_register_address;
                wdata_d   = i_write_data;
                shift_d   = {i_dev_address, 1'b0};
                byte_d    = 2'd0;
                bit_d     = 3'd0;
                qtr_d     = 3'd0;
                cnt_d     = '0;
                nack_d    = 1'b0;
                rdata_d   = 8'h00;
                busy_d    = 1'b1;
                state_d   = START;
            end
        end else if (qend) begin
            // Sampling point: end of the second SCL-high quarter.
            if (qtr_q == 3'd2) begin
                samp_d = sda_sync_q[1];
                if (state_q == RX_BYTE) shift_d = {shift_q[6:0], sda_sync_q[1]};
            end
            if (qtr_q != qtr_last) begin
                qtr_d = qtr_q + 3'd1;
            end else begin
                qtr_d = 3'd0;
                case (state_q)
                    START: begin
                        bit_d   = 3'd0;
                        state_d = TX_BYTE;
                    end
                    TX_BYTE: begin
                        if (bit_q == 3'd7) begin
                            state_d = RX_ACK;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                    RX_ACK: begin
                        bit_d = 3'd0;
                        if (samp_q) begin
                            nack_d  = 1'b1;
                            state_d = STOP;
                        end else begin
                            case (byte_q)
                                2'd0: begin
                                    byte_d  = 2'd1;
                                    shift_d = regaddr_q;
                                    state_d = TX_BYTE;
                                end
                                2'd1: begin
                                    if (rw_q) begin
                                        state_d = RSTART;
                                    end else begin
                                        byte_d  = 2'd2;
                                        shift_d = wdata_q;
                                        state_d = TX_BYTE;
                                    end
                                end
                                2'd2:    state_d = STOP;
                                default: state_d = RX_BYTE;
                            endcase
                        end
                    end
                    RSTART: begin
                        byte_d  = 2'd3;
                        bit_d   = 3'd0;
                        shift_d = {dev_q, 1'b1};
                        state_d = TX_BYTE;
                    end
                    RX_BYTE: begin
                        if (bit_q == 3'd7) begin
                            rdata_d = shift_q;
                            state_d = TX_NACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    TX_NACK: state_d = STOP;
                    STOP: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qtr_q      <= 3'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            dev_q      <= 7'h00;
            regaddr_q  <= 8'h00;
            wdata_q    <= 8'h00;
            samp_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rdata_q    <= 8'h00;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            regaddr_q  <= regaddr_d;
            wdata_q    <= wdata_d;
            samp_q     <= samp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            rdata_q    <= rdata_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end
endmodule

// File: tb/tb_i2c_controller.sv
// tb/tb_i2c_controller.sv - directed bench for i2c_controller against a behavioural target at address 0x33
`timescale 1ns/1ps
module tb_i2c_controller;
    localparam int CPQ = 62;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam time BIT_NS = 2500;
`else
    localparam time BIT_NS = 2480;
`endif
    localparam int M_IDLE = 0, M_RX = 1, M_ACK = 2, M_TX = 3, M_MACK = 4;

    logic       clk;
    logic       rst_n;
    logic       i_start, i_rw;
    logic [6:0] i_dev;
    logic [7:0] i_reg, i_wd;
    logic       o_busy, o_done, o_nack;
    logic [7:0] o_rd;
    wire        scl_w, sda_w;
    logic       tgt_sda_low = 1'b0;
    logic       tgt_scl_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign scl_w = tgt_scl_low ? 1'b0 : 1'bz;
    assign sda_w = tgt_sda_low ? 1'b0 : 1'bz;

    i2c_controller #(.CLKS_PER_QUARTER(CPQ)) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .io_scl(scl_w), .io_sda(sda_w),
        .i_start(i_start), .i_rw(i_rw), .i_dev_address(i_dev),
        .i_register_address(i_reg), .i_write_data(i_wd),
        .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack), .o_read_data(o_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rises = 0, starts = 0, stops = 0, hi_changes = 0, rx_count = 0, acks = 0;
    int rises_since_start = 0, mode = M_IDLE, bitn = 0, byte_no = 0;
    logic [7:0] rx_mem [0:63];
    logic [7:0] sh = 8'h00;
    logic reading = 1'b0, mack = 1'b0, stretch_en = 1'b0;
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    time last_rise = 0, period3 = 0;
    event stretch_ev;

    always @(stretch_ev) begin
        tgt_scl_low = 1'b1;
        #5000;
        tgt_scl_low = 1'b0;
    end

    always @(scl_w or sda_w) begin
        if (prev_scl === 1'b1 && scl_w === 1'b1 && sda_w !== prev_sda) begin
            hi_changes++;
            if (sda_w === 1'b0) begin
                starts++; mode = M_RX; bitn = 0; byte_no = 0; rises_since_start = 0;
            end else begin
                stops++; mode = M_IDLE; tgt_sda_low = 1'b0;
            end
        end else if (prev_scl !== 1'b1 && scl_w === 1'b1) begin
            rises++; rises_since_start++;
            if (rises_since_start == 3) period3 = $time - last_rise;
            last_rise = $time;
            if (mode == M_RX) begin sh = {sh[6:0], sda_w}; bitn++; end
            else if (mode == M_MACK) mack = sda_w;
        end else if (prev_scl === 1'b1 && scl_w !== 1'b1) begin
            if (mode == M_RX && bitn == 8) begin
                rx_mem[rx_count[5:0]] = sh; rx_count++;
                if (byte_no == 0) reading = sh[0];
                if (byte_no != 0 || sh[7:1] == 7'h33) begin
                    tgt_sda_low = 1'b1; mode = M_ACK; acks++;
                    if (byte_no == 1 && stretch_en) -> stretch_ev;
                end else begin
                    mode = M_IDLE;
                end
                byte_no++;
            end else if (mode == M_ACK) begin
                if (reading) begin
                    mode = M_TX; bitn = 0; sh = 8'hAA; tgt_sda_low = ~sh[7];
                end else begin
                    mode = M_RX; bitn = 0; tgt_sda_low = 1'b0;
                end
            end else if (mode == M_TX) begin
                bitn++;
                if (bitn == 8) begin tgt_sda_low = 1'b0; mode = M_MACK; end
                else tgt_sda_low = ~sh[7-bitn];
            end else if (mode == M_MACK) begin
                mode = M_IDLE;
            end
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    int b_rises, b_rx, b_acks, b_hi, b_starts, b_stops;
    int t_done, t_cycles, read_cycles;
    logic t_nack, t_busy;
    logic [7:0] t_rd;

    task automatic snap();
        b_rises = rises; b_rx = rx_count; b_acks = acks;
        b_hi = hi_changes; b_starts = starts; b_stops = stops;
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input bit poke);
        snap();
        @(negedge clk);
        i_start = 1'b1; i_rw = rw; i_dev = dev; i_reg = ra; i_wd = wd;
        @(negedge clk);
        i_start = 1'b0;
        t_busy = o_busy; t_cycles = 0; t_done = 0; t_nack = 1'b0; t_rd = 8'h00;
        while (o_busy && t_cycles < 40000) begin
            if (poke && t_cycles == 500) begin i_start = 1'b1; i_rw = ~rw; i_dev = 7'h12; i_wd = 8'h00; end
            if (poke && t_cycles == 501) i_start = 1'b0;
            @(negedge clk);
            t_cycles++;
            if (o_done) begin t_done++; t_nack = o_nack; t_rd = o_rd; end
        end
        repeat (3) begin
            @(negedge clk);
            if (o_done) t_done++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_rw = 1'b0; i_dev = 7'h00; i_reg = 8'h00; i_wd = 8'h00;
        repeat (5) @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", o_done); end
        total++; if (o_nack !== 1'b0) begin bad++; $display("FAIL rst_nack: got %b want 0", o_nack); end
        total++; if (o_rd !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", o_rd); end
        total++; if (scl_w !== 1'b1 || sda_w !== 1'b1) begin bad++; $display("FAIL rst_lines: got scl=%b sda=%b want 1 1", scl_w, sda_w); end
        rst_n = 1'b1;
        snap();
        repeat (300) @(negedge clk);
        total++; if (rises != b_rises || hi_changes != b_hi) begin bad++; $display("FAIL idle_quiet: got rises=%0d edges=%0d want 0 0", rises - b_rises, hi_changes - b_hi); end
    endtask

    task automatic test_write();
        run_txn(1'b0, 7'h33, 8'h55, 8'hAA, 1'b1);
        total++; if (t_busy !== 1'b1) begin bad++; $display("FAIL wr_busy_rise: got %b want 1", t_busy); end
        total++; if (t_done != 1) begin bad++; $display("FAIL wr_done_pulses: got %0d want 1", t_done); end
        total++; if (t_nack !== 1'b0) begin bad++; $display("FAIL wr_nack: got %b want 0", t_nack); end
        total++; if (rx_count - b_rx != 3) begin bad++; $display("FAIL wr_nbytes: got %0d want 3", rx_count - b_rx); end
        total++; if (rx_mem[b_rx % 64] !== 8'h66) begin bad++; $display("FAIL wr_byte0: got %h want 66", rx_mem[b_rx % 64]); end
        total++; if (rx_mem[(b_rx + 1) % 64] !== 8'h55) begin bad++; $display("FAIL wr_byte1: got %h want 55", rx_mem[(b_rx + 1) % 64]); end
        total++; if (rx_mem[(b_rx + 2) % 64] !== 8'hAA) begin bad++; $display("FAIL wr_byte2: got %h want aa", rx_mem[(b_rx + 2) % 64]); end
        total++; if (acks - b_acks != 3) begin bad++; $display("FAIL wr_acks: got %0d want 3", acks - b_acks); end
        total++; if (rises - b_rises != 28) begin bad++; $display("FAIL wr_scl_pulses: got %0d want 28", rises - b_rises); end
        total++; if (hi_changes - b_hi != 2 || stops - b_stops != 1) begin bad++; $display("FAIL wr_sda_hi_edges: got %0d stops=%0d want 2 1", hi_changes - b_hi, stops - b_stops); end
        total++; if (period3 !== BIT_NS) begin bad++; $display("FAIL wr_scl_period: got %0t want %0t", period3, BIT_NS); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_read();
        run_txn(1'b1, 7'h33, 8'h55, 8'h00, 1'b0);
        read_cycles = t_cycles;
        total++; if (t_done != 1) begin bad++; $display("FAIL rd_done_pulses: got %0d want 1", t_done); end
        total++; if (t_nack !== 1'b0) begin bad++; $display("FAIL rd_nack: got %b want 0", t_nack); end
        total++; if (t_rd !== 8'hAA) begin bad++; $display("FAIL rd_data: got %h want aa", t_rd); end
        total++; if (o_rd !== 8'hAA) begin bad++; $display("FAIL rd_data_hold: got %h want aa", o_rd); end
        total++; if (rx_count - b_rx != 3) begin bad++; $display("FAIL rd_nbytes: got %0d want 3", rx_count - b_rx); end
        total++; if (rx_mem[b_rx % 64] !== 8'h66) begin bad++; $display("FAIL rd_byte0: got %h want 66", rx_mem[b_rx % 64]); end
        total++; if (rx_mem[(b_rx + 1) % 64] !== 8'h55) begin bad++; $display("FAIL rd_byte1: got %h want 55", rx_mem[(b_rx + 1) % 64]); end
        total++; if (rx_mem[(b_rx + 2) % 64] !== 8'h67) begin bad++; $display("FAIL rd_byte2: got %h want 67", rx_mem[(b_rx + 2) % 64]); end
        total++; if (mack !== 1'b1) begin bad++; $display("FAIL rd_master_nack: got %b want 1", mack); end
        total++; if (starts - b_starts != 2) begin bad++; $display("FAIL rd_starts: got %0d want 2", starts - b_starts); end
        total++; if (rises - b_rises != 38) begin bad++; $display("FAIL rd_scl_pulses: got %0d want 38", rises - b_rises); end
        total++; if (hi_changes - b_hi != 3) begin bad++; $display("FAIL rd_sda_hi_edges: got %0d want 3", hi_changes - b_hi); end
    endtask

    task automatic test_nack();
        run_txn(1'b0, 7'h34, 8'h55, 8'hAA, 1'b0);
        total++; if (t_done != 1) begin bad++; $display("FAIL nk_done_pulses: got %0d want 1", t_done); end
        total++; if (t_nack !== 1'b1) begin bad++; $display("FAIL nk_nack: got %b want 1", t_nack); end
        total++; if (rx_count - b_rx != 1 || rx_mem[b_rx % 64] !== 8'h68) begin bad++; $display("FAIL nk_addr_byte: got n=%0d %h want 1 68", rx_count - b_rx, rx_mem[b_rx % 64]); end
        total++; if (rises - b_rises != 10) begin bad++; $display("FAIL nk_scl_pulses: got %0d want 10", rises - b_rises); end
        total++; if (stops - b_stops != 1) begin bad++; $display("FAIL nk_stop: got %0d want 1", stops - b_stops); end
        repeat (200) @(negedge clk);
        total++; if (o_nack !== 1'b1) begin bad++; $display("FAIL nk_nack_hold: got %b want 1", o_nack); end
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch();
        stretch_en = 1'b1;
        run_txn(1'b1, 7'h33, 8'h55, 8'h00, 1'b0);
        stretch_en = 1'b0;
        total++; if (t_done != 1 || t_nack !== 1'b0) begin bad++; $display("FAIL st_done: got %0d nack=%b want 1 0", t_done, t_nack); end
        total++; if (t_rd !== 8'hAA) begin bad++; $display("FAIL st_data: got %h want aa", t_rd); end
        total++; if (t_cycles < read_cycles + 300) begin bad++; $display("FAIL st_waited: got %0d cycles want >= %0d", t_cycles, read_cycles + 300); end
    endtask
`endif

    task automatic test_reset_mid();
        int guard;
        snap();
        @(negedge clk);
        i_start = 1'b1; i_rw = 1'b0; i_dev = 7'h33; i_reg = 8'h55; i_wd = 8'hAA;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (rises - b_rises < 22 && guard < 20000) begin @(negedge clk); guard++; end
        total++; if (guard >= 20000) begin bad++; $display("FAIL mid_reach: got timeout want data byte"); end
        repeat (150) @(negedge clk);
        total++; if (scl_w !== 1'b0 || sda_w !== 1'b0) begin bad++; $display("FAIL mid_pre_lines: got scl=%b sda=%b want 0 0", scl_w, sda_w); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (scl_w !== 1'b1 || sda_w !== 1'b1) begin bad++; $display("FAIL mid_lines_z: got scl=%b sda=%b want 1 1", scl_w, sda_w); end
        total++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_nack !== 1'b0 || o_rd !== 8'h00) begin bad++; $display("FAIL mid_outputs: got %b%b%b %h want 000 00", o_busy, o_done, o_nack, o_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (300) @(negedge clk);
        total++; if (rises != b_rises || o_busy !== 1'b0) begin bad++; $display("FAIL mid_quiet: got rises=%0d busy=%b want 0 0", rises - b_rises, o_busy); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 7'h33, 8'h10, 8'h5A, 1'b0);
        total++; if (t_done != 1 || t_nack !== 1'b0) begin bad++; $display("FAIL b2b_wr_done: got %0d nack=%b want 1 0", t_done, t_nack); end
        total++; if (rx_mem[(b_rx + 1) % 64] !== 8'h10 || rx_mem[(b_rx + 2) % 64] !== 8'h5A) begin bad++; $display("FAIL b2b_wr_bytes: got %h %h want 10 5a", rx_mem[(b_rx + 1) % 64], rx_mem[(b_rx + 2) % 64]); end
        run_txn(1'b1, 7'h33, 8'h10, 8'h00, 1'b0);
        total++; if (t_done != 1 || t_rd !== 8'hAA) begin bad++; $display("FAIL b2b_rd: got done=%0d data=%h want 1 aa", t_done, t_rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_controller.md
I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 SHALL have parameter: CLKS_PER_QUARTER, default 62, i_sys_clk cycles per quarter SCL period (100 MHz -> ~400 kHz).
REQ-002 SHALL have ports:
- i_sys_clk  input  1  system clock, all logic on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- io_scl  inout  1  open-drain I2C clock (drive 0 or Z only).
- io_sda  inout  1  open-drain I2C data (drive 0 or Z only).
- i_start  input  1  transaction request.
- i_rw  input  1  0 = register write, 1 = register read.
- i_dev_address  input  7  target 7-bit address.
- i_register_address  input  8  target register address.
- i_write_data  input  8  write payload.
- o_busy  output  1  transaction in progress.
- o_done  output  1  one-cycle completion pulse.
- o_nack  output  1  target NACKed; valid with o_done.
- o_read_data  output  8  read result; valid with o_done when i_rw=1 and o_nack=0.
REQ-003 One clock (i_sys_clk); reset i_rst_n is asynchronous, active-low.

Function
REQ-004 SHALL sample io_scl/io_sda through 2-flop synchronizers before use.
REQ-005 i_start SHALL be accepted only when o_busy=0; all request inputs captured that cycle; o_busy SHALL rise the next cycle; i_start while busy SHALL be ignored.
REQ-006 States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP.
REQ-007 Bit timing: 4 quarters per bit; SDA changes only in quarter 0 (SCL low); SCL released at quarters 1-2, pulled low at quarter 3 end; SDA sampled at end of quarter 2.
REQ-008 START: both lines released 1 quarter, SDA pulled low, hold 2 quarters, then SCL low.
REQ-009 Write sequence: START, {addr,0}, ACK, reg, ACK, data, ACK, STOP.
REQ-010 Read sequence: START, {addr,0}, ACK, reg, ACK, RSTART, {addr,1}, ACK, 8 data bits MSB-first, controller NACK (SDA released), STOP.
REQ-011 RSTART: SDA released while SCL low, SCL released 1 quarter, SDA pulled low, hold 2 quarters, SCL low.
REQ-012 Bytes SHALL be sent/received MSB first; SDA released during RX_ACK and RX_BYTE.
REQ-013 ACK slot reading 1 SHALL set nack, abort remaining bytes, go directly to STOP.
REQ-014 STOP: SDA low with SCL low 1 quarter, release SCL, wait 1 quarter, release SDA, 2 quarters bus-free, then IDLE.
REQ-015 o_done SHALL pulse exactly one cycle on IDLE entry from STOP; o_busy falls same cycle; o_nack and o_read_data SHALL hold until next accepted i_start.
REQ-016 Quarter counter SHALL count 0..CLKS_PER_QUARTER-1 and wrap; no state advance mid-quarter.

Reset
REQ-017 Asserting i_rst_n low SHALL immediately release io_scl and io_sda (Z), force IDLE, and clear o_busy, o_done, o_nack, o_read_data to 0, including mid-transaction.
REQ-018 After reset deassertion the block SHALL wait in IDLE with no bus activity until i_start.

Configuration
REQ-019 Macro I2C_CLOCK_STRETCH_EN: when defined, after releasing SCL the quarter counter SHALL hold until synchronized io_scl reads 1 (target clock stretching honoured, unbounded wait).
REQ-020 When I2C_CLOCK_STRETCH_EN is undefined, SCL timing SHALL be purely counter-driven; io_scl input ignored.

Verification
REQ-021 Write dev 0x33, reg 0x55, data 0xAA to ACKing target model -> target sees 0x66,0x55,0xAA; 3 ACKs; STOP; o_done=1, o_nack=0.
REQ-022 Read dev 0x33, reg 0x55, target returns 0xAA -> bytes 0x66,0x55, repeated START, 0x67, controller NACK, STOP; o_read_data=0xAA, o_nack=0.
REQ-023 Write to absent dev 0x34 -> NACK on first byte, STOP immediately after, o_done with o_nack=1, no further SCL pulses.
REQ-024 Timing check, CLKS_PER_QUARTER=62 -> SCL period 2480 ns, SDA stable while SCL high except START/STOP/RSTART.
REQ-025 With I2C_CLOCK_STRETCH_EN, target holds SCL low 5 us during reg ACK -> controller waits, transaction completes with correct data; i_rst_n pulsed low mid-data byte -> both lines Z within same cycle, all outputs 0.
